// File: rtl/ax301_segment_scanner_pkg.sv
// Shared types and constants for the AX301 six-digit segment display scanner.
package ax301_peripherals_pkg;

    localparam int SEG_DIGITS = 6;

    localparam logic [5:0] SEG_OFF_SEL     = 6'h3F;
    localparam logic [7:0] SEG_OFF_SEGMENT = 8'hFF;

    typedef logic [3:0] seg_hex_t;

    typedef struct packed {
        seg_hex_t [SEG_DIGITS-1:0] digits;
        logic [SEG_DIGITS-1:0]     dp;
        logic [SEG_DIGITS-1:0]     en;
    } seg_frame_t;

    // Display pin bundle; both fields are active-low at the pins.
    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] segment;
    } ax301_segment_ctrl;

    localparam seg_frame_t SEG_FRAME_EMPTY = '0;

endpackage

// File: rtl/ax301_segment_scanner_if.sv
// Frame handshake between a producer and the segment scanner.
// Valid/ready: a frame transfers on a clk edge where frame_valid && frame_ready; the producer holds data while ready is low.
interface ax301_segment_scanner_if;

    logic        frame_valid;
    logic        frame_ready;
    logic [23:0] frame_digits;
    logic [5:0]  frame_dp;
    logic [5:0]  frame_en;

    modport master (
        output frame_valid,
        output frame_digits,
        output frame_dp,
        output frame_en,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_digits,
        input  frame_dp,
        input  frame_en,
        output frame_ready
    );

endinterface

// File: rtl/ax301_seg_hex_decoder.sv
// Combinational hex to seven-segment decoder, active-high gfedcba.
module ax301_seg_hex_decoder
    import ax301_peripherals_pkg::*;
(
    input  seg_hex_t   hex,
    output logic [6:0] seg_gfedcba
);

    always_comb begin
        seg_gfedcba = 7'h00;
        case (hex)
            4'h0: seg_gfedcba = 7'h3F;
            4'h1: seg_gfedcba = 7'h06;
            4'h2: seg_gfedcba = 7'h5B;
            4'h3: seg_gfedcba = 7'h4F;
            4'h4: seg_gfedcba = 7'h66;
            4'h5: seg_gfedcba = 7'h6D;
            4'h6: seg_gfedcba = 7'h7D;
            4'h7: seg_gfedcba = 7'h07;
            4'h8: seg_gfedcba = 7'h7F;
            4'h9: seg_gfedcba = 7'h6F;
            4'hA: seg_gfedcba = 7'h77;
            4'hB: seg_gfedcba = 7'h7C;
            4'hC: seg_gfedcba = 7'h39;
            4'hD: seg_gfedcba = 7'h5E;
            4'hE: seg_gfedcba = 7'h79;
            4'hF: seg_gfedcba = 7'h71;
            default: seg_gfedcba = 7'h00;
        endcase
    end

endmodule

// File: rtl/ax301_segment_scanner.sv
// Double-buffered six-digit scan controller with per-slot blanking and registered pin outputs.
// Optional leading-zero suppression: define AX301_SEG_LEADING_ZERO_BLANK_EN.
module ax301_segment_scanner
    import ax301_peripherals_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    ax301_segment_scanner_if.slave    frame,
    output logic                      frame_start,
    output ax301_segment_ctrl         seg_ctrl
);

    localparam int              CW        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0]   SLOT_LAST = CW'(DIGIT_CYCLES - 1);

    // slot_cnt/digit_idx name the position the next clock edge presents on the pins.
    logic [CW-1:0]   slot_cnt;
    logic [2:0]      digit_idx;
    seg_frame_t      active;
    seg_frame_t      pending;
    logic            pending_full;

    logic            boundary;
    logic            promote;
    logic            accept;
    seg_frame_t      shown;
    logic            in_blank;
    logic            lit;
    logic [5:0]      lz_mask;
    logic [6:0]      hex_seg;
    logic [5:0]      sel_nxt;
    logic [7:0]      segment_nxt;

    assign frame.frame_ready = !pending_full;

    assign boundary = (slot_cnt == '0) && (digit_idx == 3'd0);
    assign promote  = boundary && pending_full;
    assign accept   = frame.frame_valid && !pending_full;
    assign shown    = promote ? pending : active;
    assign in_blank = int'(slot_cnt) < BLANK_CYCLES;

    ax301_seg_hex_decoder u_hex (
        .hex         (shown.digits[digit_idx]),
        .seg_gfedcba (hex_seg)
    );

`ifdef AX301_SEG_LEADING_ZERO_BLANK_EN
    logic zero_above;

    // Walk down from the top digit; stop suppressing once a non-zero enabled digit appears.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = SEG_DIGITS - 1; i >= 1; i--) begin
            if (shown.en[i] && (shown.digits[i] == 4'h0) && !shown.dp[i] && zero_above) begin
                lz_mask[i] = 1'b1;
            end
            if (shown.en[i] && (shown.digits[i] != 4'h0)) begin
                zero_above = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        lit         = !in_blank && shown.en[digit_idx] && !lz_mask[digit_idx];
        sel_nxt     = SEG_OFF_SEL;
        segment_nxt = SEG_OFF_SEGMENT;
        if (lit) begin
            sel_nxt     = ~(6'b000001 << digit_idx);
            segment_nxt = {~shown.dp[digit_idx], ~hex_seg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt         <= '0;
            digit_idx        <= 3'd0;
            active           <= SEG_FRAME_EMPTY;
            pending          <= SEG_FRAME_EMPTY;
            pending_full     <= 1'b0;
            frame_start      <= 1'b0;
            seg_ctrl.sel     <= SEG_OFF_SEL;
            seg_ctrl.segment <= SEG_OFF_SEGMENT;
        end else begin
            seg_ctrl.sel     <= sel_nxt;
            seg_ctrl.segment <= segment_nxt;
            frame_start      <= boundary;

            if (promote) begin
                active <= pending;
            end

            // accept and promote are exclusive: promote needs a full pending buffer.
            if (accept) begin
                pending.digits <= frame.frame_digits;
                pending.dp     <= frame.frame_dp;
                pending.en     <= frame.frame_en;
                pending_full   <= 1'b1;
            end else if (promote) begin
                pending_full   <= 1'b0;
            end

            if (slot_cnt == SLOT_LAST) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                slot_cnt  <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ax301_segment_scanner.sv
// Directed bench for ax301_segment_scanner with 8-cycle slots and 2-cycle blanking (48-cycle frames).
module tb_ax301_segment_scanner;
    import ax301_peripherals_pkg::*;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FR = 6 * DC;

`ifdef AX301_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [5:0] B_SEL3 = 6'h3F;
    localparam logic [5:0] B_SEL4 = 6'h3F;
    localparam logic [5:0] B_SEL5 = 6'h3F;
    localparam logic [7:0] B_ZSEG = 8'hFF;
`else
    localparam logic [5:0] B_SEL3 = 6'h37;
    localparam logic [5:0] B_SEL4 = 6'h2F;
    localparam logic [5:0] B_SEL5 = 6'h1F;
    localparam logic [7:0] B_ZSEG = 8'hC0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    ax301_segment_ctrl seg_ctrl;

    ax301_segment_scanner_if fif ();

    ax301_segment_scanner #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (fif),
        .frame_start (frame_start),
        .seg_ctrl    (seg_ctrl)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pos    = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until the bench's own frame position reaches target.
    task automatic goto(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            pos = (pos + 1) % FR;
            n++;
        end while ((pos != target) && (n < 2 * FR));
        if (pos != target) begin
            chk("goto_bound", 32'(pos), 32'(target));
        end
    endtask

    task automatic drive(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en);
        fif.frame_valid  = 1'b1;
        fif.frame_digits = d;
        fif.frame_dp     = dp;
        fif.frame_en     = en;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] s, input logic [7:0] g);
        chk({tag, "_sel"}, 32'(seg_ctrl.sel), 32'(s));
        chk({tag, "_seg"}, 32'(seg_ctrl.segment), 32'(g));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst              = 1'b1;
        fif.frame_valid  = 1'b0;
        fif.frame_digits = 24'h0;
        fif.frame_dp     = 6'h0;
        fif.frame_en     = 6'h0;
        repeat (3) @(negedge clk);
        chk_out("reset", 6'h3F, 8'hFF);
        chk("reset_start", 32'(frame_start), 32'd0);
        chk("reset_ready", 32'(fif.frame_ready), 32'd1);

        // Frame 0: display empty, load digits 5..0
        rst = 1'b0;
        @(negedge clk);
        pos = 0;
        chk("f0_start", 32'(frame_start), 32'd1);
        chk("f0_ready", 32'(fif.frame_ready), 32'd1);
        drive(24'h543210, 6'h00, 6'h3F);
        goto(1);
        fif.frame_valid = 1'b0;
        chk("f0_ready_after_accept", 32'(fif.frame_ready), 32'd0);
        chk("f0_start_low", 32'(frame_start), 32'd0);
        goto(10);
        chk_out("f0_empty", 6'h3F, 8'hFF);

        // Frame 1: decode of 543210
        goto(0);
        chk("f1_start", 32'(frame_start), 32'd1);
        chk("f1_ready", 32'(fif.frame_ready), 32'd1);
        chk_out("f1_blank0", 6'h3F, 8'hFF);
        goto(1);
        chk_out("f1_blank1", 6'h3F, 8'hFF);
        goto(2);
        chk_out("f1_d0_first", 6'h3E, 8'hC0);
        goto(7);
        chk_out("f1_d0_last", 6'h3E, 8'hC0);
        goto(8);
        chk_out("f1_d1_blank", 6'h3F, 8'hFF);
        goto(10);
        chk_out("f1_d1", 6'h3D, 8'hF9);

        // Frame A accepted mid-frame; B offered while ready is low must be dropped
        goto(20);
        drive(24'h000000, 6'b000001, 6'b000001);
        goto(21);
        fif.frame_valid = 1'b0;
        chk("f1_ready_a", 32'(fif.frame_ready), 32'd0);
        goto(30);
        drive(24'h000120, 6'h00, 6'h3F);
        goto(35);
        fif.frame_valid = 1'b0;
        chk("f1_ready_hold", 32'(fif.frame_ready), 32'd0);
        goto(42);
        chk_out("f1_d5_no_tear", 6'h1F, 8'h92);

        // Frame 2: A shown (only digit 0, dp lit)
        goto(0);
        chk("f2_start", 32'(frame_start), 32'd1);
        chk("f2_ready", 32'(fif.frame_ready), 32'd1);
        goto(2);
        chk_out("f2_d0", 6'h3E, 8'h40);
        goto(7);
        chk_out("f2_d0_last", 6'h3E, 8'h40);
        goto(10);
        chk_out("f2_d1_dark", 6'h3F, 8'hFF);
        goto(45);
        chk_out("f2_d5_dark", 6'h3F, 8'hFF);
        goto(47);
        chk("f2_start_low", 32'(frame_start), 32'd0);
        drive(24'h000120, 6'h00, 6'h3F);

        // Frame 3: B accepted on the boundary edge, A still displayed
        goto(0);
        fif.frame_valid = 1'b0;
        chk("f3_start", 32'(frame_start), 32'd1);
        chk("f3_ready_b", 32'(fif.frame_ready), 32'd0);
        goto(2);
        chk_out("f3_d0_still_a", 6'h3E, 8'h40);
        goto(10);
        chk_out("f3_d1_still_a", 6'h3F, 8'hFF);

        // Frame 4: B = 000120
        goto(0);
        chk("f4_ready", 32'(fif.frame_ready), 32'd1);
        goto(2);
        chk_out("f4_d0", 6'h3E, 8'hC0);
        goto(10);
        chk_out("f4_d1", 6'h3D, 8'hA4);
        goto(18);
        chk_out("f4_d2", 6'h3B, 8'hF9);
        goto(26);
        chk_out("f4_d3", B_SEL3, B_ZSEG);
        goto(34);
        chk_out("f4_d4", B_SEL4, B_ZSEG);
        goto(42);
        chk_out("f4_d5", B_SEL5, B_ZSEG);

        // Frame 5: load C, then reset in the digit-3 slot discards it
        goto(0);
        goto(20);
        drive(24'h543210, 6'h00, 6'h3F);
        goto(21);
        fif.frame_valid = 1'b0;
        chk("f5_ready_c", 32'(fif.frame_ready), 32'd0);
        goto(28);
        rst = 1'b1;
        @(negedge clk);
        chk_out("midrst", 6'h3F, 8'hFF);
        chk("midrst_start", 32'(frame_start), 32'd0);
        chk("midrst_ready", 32'(fif.frame_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        pos = 0;
        chk("post_rst_start", 32'(frame_start), 32'd1);
        goto(2);
        chk_out("post_rst_d0", 6'h3F, 8'hFF);
        goto(47);
        chk("post_rst_start_low", 32'(frame_start), 32'd0);
        goto(0);
        chk("post_rst_start_next", 32'(frame_start), 32'd1);
        goto(2);
        chk_out("post_rst_no_promote", 6'h3F, 8'hFF);
        goto(10);
        chk_out("post_rst_d1", 6'h3F, 8'hFF);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
